mac_result_drain: RTL and testbench

- Output-side counterpart of the MAC controller. The controller feeds operands into the N x N MAC array and pulses done.
- This block snapshots the array's N x N accumulator results in one cycle.
- It then streams them out one element per beat, row-major, over a valid/ready interface toward the result writer/host.
- Each element is scaled by a right shift and saturated to the output width. Captures that arrive while the previous matrix is still draining are flagged.

---
 rtl/mac_result_drain.sv | 100 ++++++++++
 tb/tb_mac_result_drain.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_drain.sv
// Snapshots the N x N MAC accumulators in one cycle and streams them row-major, one scaled/saturated
// element per beat; latency is one cycle from capture to first beat and stalls hold the beat stable.
module mac_result_drain #(
    parameter int N     = 4,
    parameter int ACC_W = 18,
    parameter int OUT_W = 8,
    parameter int SHIFT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N*N*ACC_W-1:0]    acc_in,
    input  logic                    acc_valid,
    output logic                    acc_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(N)-1:0]    out_row,
    output logic [$clog2(N)-1:0]    out_col,
    output logic                    out_last,
    output logic                    out_sat,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clr
);
    localparam int RW = $clog2(N);
    localparam int IW = $clog2(N * N);
    localparam logic [ACC_W-1:0] MAXV = ACC_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t             state;
    logic [ACC_W-1:0]   snap [N*N];
    logic               fire;
    logic               capture;
    logic               drop;
    logic               last_pos;
    logic [IW-1:0]      sel;
    logic [ACC_W-1:0]   cur;
    logic [ACC_W-1:0]   scaled;
    logic               sat;

    assign last_pos  = (out_row == RW'(N - 1)) && (out_col == RW'(N - 1));
    assign out_valid = (state == DRAIN);
    assign busy      = out_valid;
    assign fire      = out_valid & out_ready;
    assign out_last  = out_valid & last_pos;
    // A new matrix is accepted when idle or on the very beat that retires the old one.
    assign acc_ready = ~reset & ((state == IDLE) | (fire & last_pos));
    assign capture   = acc_valid & acc_ready;
    assign drop      = acc_valid & ~acc_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            out_row <= '0;
            out_col <= '0;
            overrun <= 1'b0;
        end else begin
            if (capture) begin
                state   <= DRAIN;
                out_row <= '0;
                out_col <= '0;
            end else if (fire) begin
                if (last_pos) begin
                    state <= IDLE;
                end
                if (out_col == RW'(N - 1)) begin
                    out_col <= '0;
                    out_row <= last_pos ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Snapshot contents are don't-care out of reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N * N; i++) begin
                snap[i] <= acc_in[i*ACC_W +: ACC_W];
            end
        end
    end

    assign sel    = IW'(out_row) * IW'(N) + IW'(out_col);
    assign cur    = snap[sel];
    assign scaled = cur >> SHIFT;
    assign sat    = (scaled > MAXV);

    // Gated by out_valid so the outputs read zero while idle or in reset.
    assign out_data = !out_valid ? '0 : (sat ? '1 : scaled[OUT_W-1:0]);
    assign out_sat  = out_valid & sat;

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain: table-driven transform vectors plus stream, stall, overrun,
// back-to-back and mid-drain reset sequences.
module tb_mac_result_drain;
    localparam int N     = 4;
    localparam int ACC_W = 18;
    localparam int OUT_W = 8;
    localparam int MW    = N * N * ACC_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [MW-1:0]      acc_in = '0;
    logic               acc_valid = 1'b0;
    logic               acc_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [1:0]         out_row;
    logic [1:0]         out_col;
    logic               out_last;
    logic               out_sat;
    logic               busy;
    logic               overrun;
    logic               overrun_clr = 1'b0;

    mac_result_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(2)) dut (
        .clk(clk), .reset(reset), .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_col(out_col), .out_last(out_last), .out_sat(out_sat), .busy(busy),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [OUT_W-1:0] d;
        logic             s;
    } vec_t;

    vec_t           tbl [16];
    logic [7:0]     exp_d [16];
    logic           exp_s [16];
    bit             inj [256];
    bit             clr [256];
    logic [MW-1:0]  inj_data;
    logic [MW-1:0]  m_count;
    logic [MW-1:0]  m_tbl;
    bit             ov_m = 1'b0;
    int             n_cmp = 0;
    int             n_bad = 0;
    int             ncyc;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic clear_ev();
        for (int i = 0; i < 256; i++) begin
            inj[i] = 1'b0;
            clr[i] = 1'b0;
        end
    endtask

    task automatic load(input logic [MW-1:0] m);
        @(negedge clk);
        acc_valid   = 1'b1;
        acc_in      = m;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        #1;
        chk("load_ready", 0, acc_ready, 1);
        chk("load_idle_valid", 0, out_valid, 0);
    endtask

    task automatic idle_check(input int tag);
        @(negedge clk);
        acc_valid   = 1'b0;
        overrun_clr = 1'b0;
        out_ready   = 1'b1;
        #1;
        chk("idle_valid", tag, out_valid, 0);
        chk("idle_busy", tag, busy, 0);
        chk("idle_ready", tag, acc_ready, 1);
        chk("idle_overrun", tag, overrun, ov_m);
    endtask

    // Drives one drain, checking every beat against exp_d/exp_s and overrun against a small model.
    task automatic drain(input bit bp, input int rst_beat, output int cycles);
        int beat = 0;
        int cyc  = 0;
        bit exp_rdy;
        cycles = 0;
        while (beat < 16 && cyc < 200) begin
            @(negedge clk);
            out_ready   = bp ? (cyc % 2 == 0) : 1'b1;
            acc_valid   = inj[cyc];
            overrun_clr = clr[cyc];
            acc_in      = inj[cyc] ? inj_data : '0;
            if (beat == rst_beat) begin
                reset = 1'b1;
                #1;
                chk("rst_valid", beat, out_valid, 0);
                chk("rst_busy", beat, busy, 0);
                chk("rst_overrun", beat, overrun, 0);
                chk("rst_data", beat, out_data, 0);
                ov_m        = 1'b0;
                acc_valid   = 1'b0;
                overrun_clr = 1'b0;
                cycles      = cyc;
                return;
            end
            #1;
            chk("valid", beat, out_valid, 1);
            chk("busy", beat, busy, 1);
            chk("data", beat, out_data, exp_d[beat]);
            chk("sat", beat, out_sat, exp_s[beat]);
            chk("row", beat, out_row, beat / 4);
            chk("col", beat, out_col, beat % 4);
            chk("last", beat, out_last, beat == 15);
            chk("overrun", cyc, overrun, ov_m);
            exp_rdy = out_ready && (beat == 15);
            chk("acc_ready", cyc, acc_ready, exp_rdy);
            if (acc_valid && !exp_rdy) ov_m = 1'b1;
            else if (overrun_clr) ov_m = 1'b0;
            if (out_ready) beat++;
            cyc++;
        end
        chk("drain_done", cyc, beat, 16);
        cycles = cyc;
    endtask

    task automatic set_count_exp();
        for (int i = 0; i < 16; i++) begin
            exp_d[i] = 8'(i);
            exp_s[i] = 1'b0;
        end
    endtask

    task automatic set_tbl_exp();
        for (int i = 0; i < 16; i++) begin
            exp_d[i] = tbl[i].d;
            exp_s[i] = tbl[i].s;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{18'h3FFFF, 8'hFF, 1'b1};
        tbl[1]  = '{18'd1020,  8'hFF, 1'b0};
        tbl[2]  = '{18'd1024,  8'hFF, 1'b1};
        tbl[3]  = '{18'd1023,  8'hFF, 1'b0};
        tbl[4]  = '{18'd0,     8'h00, 1'b0};
        tbl[5]  = '{18'd4,     8'h01, 1'b0};
        tbl[6]  = '{18'd3,     8'h00, 1'b0};
        tbl[7]  = '{18'd7,     8'h01, 1'b0};
        tbl[8]  = '{18'd8,     8'h02, 1'b0};
        tbl[9]  = '{18'd512,   8'h80, 1'b0};
        tbl[10] = '{18'd1019,  8'hFE, 1'b0};
        tbl[11] = '{18'd2000,  8'hFF, 1'b1};
        tbl[12] = '{18'd100,   8'h19, 1'b0};
        tbl[13] = '{18'd255,   8'h3F, 1'b0};
        tbl[14] = '{18'd256,   8'h40, 1'b0};
        tbl[15] = '{18'd1021,  8'hFF, 1'b0};
        for (int i = 0; i < 16; i++) begin
            m_tbl[i*ACC_W +: ACC_W]   = tbl[i].acc;
            m_count[i*ACC_W +: ACC_W] = 18'(4 * i);
            inj_data[i*ACC_W +: ACC_W] = 18'h3FFFF;
        end
        clear_ev();

        // Reset state
        #1;
        chk("rst_out_valid", 0, out_valid, 0);
        chk("rst_busy", 0, busy, 0);
        chk("rst_overrun", 0, overrun, 0);
        chk("rst_out_data", 0, out_data, 0);
        chk("rst_last", 0, out_last, 0);
        chk("rst_sat", 0, out_sat, 0);
        chk("rst_row", 0, out_row, 0);
        chk("rst_col", 0, out_col, 0);
        chk("rst_acc_ready", 0, acc_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 0, acc_ready, 1);

        // Table of transform vectors, including the saturation boundary values
        set_tbl_exp();
        load(m_tbl);
        drain(1'b0, -1, ncyc);
        idle_check(1);

        // Counting stream at full rate
        set_count_exp();
        load(m_count);
        drain(1'b0, -1, ncyc);
        chk("full_rate_cycles", 0, ncyc, 16);
        idle_check(2);

        // Alternating backpressure
        load(m_count);
        drain(1'b1, -1, ncyc);
        chk("bp_cycles", 0, ncyc, 31);
        idle_check(3);

        // Overrun: drop on beat 5, drop+clear together, then clear alone
        clear_ev();
        inj[4] = 1'b1;
        inj[8] = 1'b1;
        clr[8] = 1'b1;
        clr[11] = 1'b1;
        load(m_count);
        drain(1'b0, -1, ncyc);
        chk("ov_model_cleared", 0, ov_m, 0);

        // Back-to-back: capture on the final handshake, no bubble
        clear_ev();
        inj[15] = 1'b1;
        inj_data = m_tbl;
        load(m_count);
        drain(1'b0, -1, ncyc);
        clear_ev();
        set_tbl_exp();
        drain(1'b0, -1, ncyc);
        chk("b2b_overrun", 0, overrun, 0);
        idle_check(4);

        // Reset during beat 7 with overrun set beforehand
        clear_ev();
        for (int i = 0; i < 16; i++) inj_data[i*ACC_W +: ACC_W] = 18'h3FFFF;
        inj[2] = 1'b1;
        set_count_exp();
        load(m_count);
        drain(1'b0, 6, ncyc);
        chk("rst_abort_cycle", 0, ncyc, 6);
        @(negedge clk);
        reset = 1'b0;
        clear_ev();
        load(m_count);
        drain(1'b0, -1, ncyc);
        idle_check(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
